// File: rtl/dsec_pkg.sv
// Shared definitions for the output stage of the compression/encryption top.
//   - error codes reported on error_code
//   - flush sequencer state encoding
package dsec_pkg;

   localparam logic [63:0] ERR_NONE          = 64'h0;
   localparam logic [63:0] ERR_OVERFLOW      = 64'h1;
   localparam logic [63:0] ERR_FLUSH_TIMEOUT = 64'h2;
   localparam logic [63:0] ERR_SPURIOUS_RCVD = 64'h3;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      FLUSH     = 2'd1,
      WAIT_SCON = 2'd2,
      DRAIN     = 2'd3
   } flush_state_e;

endpackage

// File: rtl/dsec_sync_fifo.sv
// Synchronous FIFO buffering output words.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   push, wdata   write request and word; ignored when full unless popping
//   pop           read request; ignored when empty
//   rdata         head entry (stale contents when empty)
//   count         occupancy 0..DEPTH
//   full, empty   occupancy flags
module dsec_sync_fifo #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [DATA_W-1:0]        wdata,
   input  logic                     pop,
   output logic [DATA_W-1:0]        rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              push_ok, pop_ok;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign rdata = mem_q[rd_ptr_q];

   // A pop in the same cycle frees the slot, so a push into a full FIFO is fine then.
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/dsec_out_ctrl.sv
// Output-stage controller: buffers words from the shift-concatenation stage,
// hands them out with an out_valid/out_rcvd handshake, backpressures upstream
// and sequences end-of-stream flushes.
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   key_config                freezes the whole output stage while high
//   scon_done, scon_data      incoming word strobe and data
//   flush_req                 single-cycle end-of-stream flush request
//   out_rcvd                  receiver took out_data this cycle
//   out_data, out_valid       head word and its valid
//   stall                     upstream must hold
//   dump_comp                 one-cycle pulse asking compression for residual bits
//   flush_done                one-cycle pulse when the flush has drained
//   error, error_code         sticky error flag and first error code
//   fill_level                FIFO occupancy
//
// state     | meaning
// IDLE      | normal streaming, waiting for flush_req
// FLUSH     | dump_comp asserted for one cycle, timer loaded
// WAIT_SCON | waiting for the final word, timer counting down
// DRAIN     | waiting for the FIFO to empty, then flush_done
module dsec_out_ctrl
   import dsec_pkg::*;
#(
   parameter int DATA_W  = 64,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    key_config,
   input  logic                    scon_done,
   input  logic [DATA_W-1:0]       scon_data,
   input  logic                    flush_req,
   input  logic                    out_rcvd,
   output logic [DATA_W-1:0]       out_data,
   output logic                    out_valid,
   output logic                    stall,
   output logic                    dump_comp,
   output logic                    flush_done,
   output logic                    error,
   output logic [63:0]             error_code,
   output logic [$clog2(DEPTH):0]  fill_level
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int TMR_W = $clog2(TIMEOUT);

   flush_state_e      state_q, state_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic              error_q, error_d;
   logic [63:0]       error_code_q, error_code_d;
   logic [63:0]       err_new;
   logic              timeout;

   logic [CNT_W-1:0]  count;
   logic              fifo_full, fifo_empty;
   logic              push_req, pop_req, overflow, spurious;

   assign push_req = scon_done & ~key_config;
   assign pop_req  = out_rcvd & ~key_config & ~fifo_empty;
   assign overflow = push_req & fifo_full & ~pop_req;
   assign spurious = out_rcvd & ~key_config & fifo_empty;

   dsec_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_req),
      .wdata (scon_data),
      .pop   (pop_req),
      .rdata (out_data),
      .count (count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign out_valid  = ~fifo_empty & ~key_config;
   // Threshold one below full leaves room for a push already in flight.
   assign stall      = key_config | error_q | (count >= CNT_W'(DEPTH - 1));
   assign dump_comp  = (state_q == FLUSH) & ~key_config;
   assign flush_done = (state_q == DRAIN) & fifo_empty & ~key_config;
   assign error      = error_q;
   assign error_code = error_code_q;
   assign fill_level = count;

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      timeout = 1'b0;
      if (!key_config) begin
         case (state_q)
            IDLE: begin
               if (flush_req) state_d = FLUSH;
            end
            FLUSH: begin
               state_d = WAIT_SCON;
               timer_d = TMR_W'(TIMEOUT - 1);
            end
            WAIT_SCON: begin
               if (scon_done) begin
                  state_d = DRAIN;
               end else if (timer_q == '0) begin
                  timeout = 1'b1;
                  state_d = DRAIN;
               end else begin
                  timer_d = timer_q - TMR_W'(1);
               end
            end
            DRAIN: begin
               if (fifo_empty) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end

      err_new = ERR_NONE;
      if (overflow)      err_new = ERR_OVERFLOW;
      else if (timeout)  err_new = ERR_FLUSH_TIMEOUT;
      else if (spurious) err_new = ERR_SPURIOUS_RCVD;
      error_d      = error_q | (err_new != ERR_NONE);
      error_code_d = error_q ? error_code_q : err_new;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         timer_q      <= '0;
         error_q      <= 1'b0;
         error_code_q <= '0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         error_q      <= error_d;
         error_code_q <= error_code_d;
      end
   end

endmodule
